// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and sizes for the data-memory arbiter
// (CPU execute stage vs. display/debug read port).
package dmem_arb_pkg;

  localparam int DMEM_AW  = 8;
  localparam int DMEM_DW  = 32;
  localparam int LANES    = 4;
  localparam int LANE_W   = DMEM_DW / LANES;
  localparam int STARVE_W = 4;

  // S_OPEN: a debug grant may be issued this cycle.
  // S_RESP: debug ack cycle; the CPU owns memory unconditionally.
  typedef enum logic {
    S_OPEN = 1'b0,
    S_RESP = 1'b1
  } arb_state_e;

  // Byte-lane write enables qualified by the access strobe.
  function automatic logic [LANES-1:0] lane_wren(input logic [LANES-1:0] we,
                                                 input logic             req);
    return we & {LANES{req}};
  endfunction

endpackage

// File: rtl/dmem_arb_starve.sv
// dmem_arb_starve: saturating count of cycles a debug request has waited
// behind the CPU; 'forced' tells the arbiter to take the memory anyway.
module dmem_arb_starve
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                sysclk,
  input  logic                cpu_resetn,
  input  logic                in_open,
  input  logic                dbg_req,
  input  logic                cpu_req,
  input  logic                dbg_grant,
  output logic                forced,
  output logic [STARVE_W-1:0] starve_cnt
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] cnt_nxt;

  // Next count: hold in the ack cycle, clear on grant or dropped request,
  // otherwise count CPU-blocked cycles up to the limit.
  always_comb begin
    cnt_nxt = starve_cnt;
    if (in_open) begin
      if (dbg_grant || !dbg_req) begin
        cnt_nxt = '0;
      end else if (cpu_req && (starve_cnt != LIMIT)) begin
        cnt_nxt = starve_cnt + 1'b1;
      end
    end
  end

  // Counter register.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= cnt_nxt;
    end
  end

  assign forced = (starve_cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one set of byte-lane data memories between the CPU
// execute stage and a read-only display/debug port. The CPU normally wins;
// a debug request that has waited STARVE_LIMIT cycles steals one cycle and
// stalls the CPU. Debug read data is registered and flagged by a one-cycle
// dbg_ack.
// Optional build macro: DMEM_ARB_PERF_EN adds the stall_cycles and
// dbg_grants performance counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic               sysclk,
  input  logic               cpu_resetn,
  input  logic               cpu_req,
  input  logic [LANES-1:0]   cpu_we,
  input  logic [DMEM_AW-1:0] cpu_addr,
  input  logic [DMEM_DW-1:0] cpu_wdata,
  output logic [DMEM_DW-1:0] cpu_rdata,
  output logic               cpu_stall,
  input  logic               dbg_req,
  input  logic [DMEM_AW-1:0] dbg_addr,
  output logic               dbg_ack,
  output logic [DMEM_DW-1:0] dbg_rdata,
  output logic [DMEM_AW-1:0] mem_addr,
  output logic [LANES-1:0]   mem_wren,
  output logic [DMEM_DW-1:0] mem_wdata,
  input  logic [DMEM_DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        dbg_grants
`endif
);

  arb_state_e          state_q;
  arb_state_e          state_nxt;
  logic                dbg_grant;
  logic                forced;
  logic [STARVE_W-1:0] starve_cnt;
  logic                vld_p1;
  logic [DMEM_DW-1:0]  dbg_rdata_p1;

  dmem_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .sysclk     (sysclk),
    .cpu_resetn (cpu_resetn),
    .in_open    (state_q == S_OPEN),
    .dbg_req    (dbg_req),
    .cpu_req    (cpu_req),
    .dbg_grant  (dbg_grant),
    .forced     (forced),
    .starve_cnt (starve_cnt)
  );

  // Arbitration: debug wins when the CPU is idle or it has starved long
  // enough; the ack cycle ignores dbg_req so grants are at least 2 apart.
  always_comb begin
    state_nxt = state_q;
    dbg_grant = 1'b0;
    unique case (state_q)
      S_OPEN: begin
        if (dbg_req && (!cpu_req || forced)) begin
          dbg_grant = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        state_nxt = S_OPEN;
      end
      default: begin
        state_nxt = S_OPEN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q <= S_OPEN;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Memory port steering: debug reads never write, the CPU path passes
  // its byte enables through only when it is actually accessing.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wren  = lane_wren(cpu_we, cpu_req);
    mem_wdata = cpu_wdata;
    if (dbg_grant) begin
      mem_addr = dbg_addr;
      mem_wren = '0;
    end
  end

  assign cpu_rdata = mem_rdata;
  assign cpu_stall = dbg_grant & cpu_req;

  // Stage p0 -> p1: capture debug read data at the grant edge, ack next cycle.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      vld_p1       <= 1'b0;
      dbg_rdata_p1 <= '0;
    end else begin
      vld_p1 <= dbg_grant;
      if (dbg_grant) begin
        dbg_rdata_p1 <= mem_rdata;
      end
    end
  end

  assign dbg_ack   = vld_p1;
  assign dbg_rdata = dbg_rdata_p1;

`ifdef DMEM_ARB_PERF_EN
  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      stall_cycles <= '0;
      dbg_grants   <= '0;
    end else begin
      stall_cycles <= stall_cycles + {31'd0, cpu_stall};
      dbg_grants   <= dbg_grants + {31'd0, dbg_grant};
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized + directed bench for dmem_arbiter. A
// behavioural model (cooldown flag + wait counter + word memory) predicts
// the memory port each cycle; predicted debug read data goes into a
// scoreboard queue popped by a monitor whenever dbg_ack is seen.
module tb_dmem_arbiter;

  localparam int LIM = 8;

  logic        sysclk;
  logic        cpu_resetn;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req;
  logic [7:0]  dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_wren;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] dbg_grants;
`endif

  dmem_arbiter #(
    .STARVE_LIMIT (LIM)
  ) dut (
    .sysclk     (sysclk),
    .cpu_resetn (cpu_resetn),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dbg_req    (dbg_req),
    .dbg_addr   (dbg_addr),
    .dbg_ack    (dbg_ack),
    .dbg_rdata  (dbg_rdata),
`ifdef DMEM_ARB_PERF_EN
    .stall_cycles (stall_cycles),
    .dbg_grants   (dbg_grants),
`endif
    .mem_addr   (mem_addr),
    .mem_wren   (mem_wren),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Physical memory seen by the DUT (written from DUT's mem port).
  logic [31:0] tb_mem [256];
  assign mem_rdata = tb_mem[mem_addr];

  // Reference model state.
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q [$];
  bit          m_cool;
  int          m_wait;
  int          m_stalls;
  int          m_grants;
  int          dut_stalls;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every ack must match the oldest predicted read.
  always @(negedge sysclk) begin
    if (cpu_resetn === 1'b1 && dbg_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: got dbg_ack=1 expected no ack at %0t", $time);
      end else begin
        chk("dbg_rdata", dbg_rdata, exp_q.pop_front());
      end
    end
  end

  // One clock cycle: called at posedge+1, returns at next posedge+1.
  task automatic cycle(input logic creq, input logic [3:0] we, input logic [7:0] ca,
                       input logic [31:0] wd, input logic dreq, input logic [7:0] da);
    logic        grant;
    logic [3:0]  ewren;
    logic [3:0]  s_wren;
    logic [7:0]  s_addr;
    logic [31:0] s_wdata;
    cpu_req   = creq;
    cpu_we    = we;
    cpu_addr  = ca;
    cpu_wdata = wd;
    dbg_req   = dreq;
    dbg_addr  = da;
    grant = dreq && !m_cool && (!creq || m_wait >= LIM);
    ewren = grant ? 4'h0 : (creq ? we : 4'h0);
    if (grant) exp_q.push_back(ref_mem[da]);
    @(negedge sysclk);
    chk("mem_addr", 32'(mem_addr), 32'(grant ? da : ca));
    chk("mem_wren", 32'(mem_wren), 32'(ewren));
    chk("cpu_stall", 32'(cpu_stall), 32'(grant && creq));
    chk("dbg_ack", 32'(dbg_ack), 32'(m_cool));
    if (ewren != 4'h0) chk("mem_wdata", mem_wdata, wd);
    if (creq && !grant) chk("cpu_rdata", cpu_rdata, ref_mem[ca]);
    if (cpu_stall) dut_stalls++;
    s_wren  = mem_wren;
    s_addr  = mem_addr;
    s_wdata = mem_wdata;
    @(posedge sysclk);
    for (int l = 0; l < 4; l++) begin
      if (s_wren[l]) tb_mem[s_addr][8*l +: 8] = s_wdata[8*l +: 8];
      if (ewren[l])  ref_mem[ca][8*l +: 8]    = wd[8*l +: 8];
    end
    if (!m_cool) begin
      if (grant || !dreq) m_wait = 0;
      else if (m_wait < LIM) m_wait++;
    end
    m_cool = grant;
    if (grant) m_grants++;
    if (grant && creq) m_stalls++;
    #1;
  endtask

  // Asynchronous reset pulse, asserted at posedge+1 (mid-cycle).
  task automatic do_reset();
    cpu_req    = 1'b1;
    cpu_we     = 4'h0;
    dbg_req    = 1'b1;
    cpu_resetn = 1'b0;
    m_cool     = 1'b0;
    m_wait     = 0;
    m_stalls   = 0;
    m_grants   = 0;
    exp_q.delete();
    @(negedge sysclk);
    chk("rst_dbg_ack", 32'(dbg_ack), 32'(0));
    chk("rst_cpu_stall", 32'(cpu_stall), 32'(0));
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);
`ifdef DMEM_ARB_PERF_EN
    chk("rst_stall_cycles", stall_cycles, 32'h0);
    chk("rst_dbg_grants", dbg_grants, 32'h0);
`endif
    @(posedge sysclk);
    #1;
    cpu_resetn = 1'b1;
  endtask

  initial begin
    logic       dreq_r;
    logic [7:0] da_r;
    logic       burst;
    logic [31:0] v;
    cpu_resetn = 1'b0;
    cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = 8'h0; cpu_wdata = 32'h0;
    dbg_req = 1'b0; dbg_addr = 8'h0;
    m_cool = 1'b0; m_wait = 0; m_stalls = 0; m_grants = 0; dut_stalls = 0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      tb_mem[i]  = v;
      ref_mem[i] = v;
    end
    tb_mem[8'h90]  = 32'd97;
    ref_mem[8'h90] = 32'd97;
    repeat (2) @(posedge sysclk);
    #1;
    do_reset();

    // Uncontended debug read of 0x90 (holds 97).
    cycle(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h90);
    cycle(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h90);
    cycle(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);

    // Starvation: CPU stores every cycle, debug waits LIM cycles then steals one.
    dut_stalls = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'hF, 8'(8'h40 + i), $urandom, 1'b1, 8'h22);
    cycle(1'b1, 4'hF, 8'h50, $urandom, 1'b0, 8'h22);
    chk("forced_stall_count", 32'(dut_stalls), 32'd1);

    // CPU store and debug read to the same word in the same cycle.
    cycle(1'b1, 4'hF, 8'h85, 32'h315, 1'b1, 8'h85);
    cycle(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h85);
    cycle(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h85);

    // dbg_req held across ack: grants at most every other cycle.
    for (int i = 0; i < 6; i++) cycle(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'(8'h60 + i));
    cycle(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);

    // Reset in the ack cycle drops the pending ack.
    cycle(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h10);
    do_reset();
    // Reset with a partially built starvation count.
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'h0, 8'(i), 32'h0, 1'b1, 8'h11);
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'h0, 8'(i), 32'h0, 1'b1, 8'h12);
    cycle(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);

    // Three forced grants from a clean reset.
    do_reset();
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < LIM + 1; i++) cycle(1'b1, 4'h3, 8'(8'h20 + i), $urandom, 1'b1, 8'(8'h30 + g));
      cycle(1'b1, 4'h0, 8'h21, 32'h0, 1'b0, 8'h00);
    end
`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall_cycles", stall_cycles, 32'd3);
    chk("perf_dbg_grants", dbg_grants, 32'd3);
`endif

    // Randomized traffic on a small address window.
    dreq_r = 1'b0;
    da_r   = 8'h0;
    burst  = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) burst = ~burst;
      if (!dreq_r) begin
        if ($urandom_range(0, 3) == 0) begin
          dreq_r = 1'b1;
          da_r   = 8'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 15) == 0) begin
        dreq_r = 1'b0;
      end
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cycle(burst ? 1'b1 : ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
              8'($urandom_range(0, 15)), $urandom, dreq_r, da_r);
      end
    end
    cycle(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
    cycle(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall_final", stall_cycles, 32'(m_stalls));
    chk("perf_grants_final", dbg_grants, 32'(m_grants));
`endif
    chk("pending_acks", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
